axi4_burst_delayer: RTL and testbench

AXI4_BURST_DELAYER -- requirements
Module: axi4_burst_delayer

---
 rtl/axi4_burst_delayer.sv | 250 +++++++++++++++++++++++++
 tb/tb_axi4_burst_delayer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_delayer.sv
// rtl/axi4_burst_delayer.sv - AXI4 shim that delays R beats and B responses in proportion to their downstream latency
module axi4_burst_delayer #(
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LAT_MUL = 5,
  parameter int DEPTH   = 8,
  parameter int ENABLE  = 1
) (
  input  logic                clock,
  input  logic                reset,
  // upstream slave side
  input  logic [ID_W-1:0]     in_awid,
  input  logic [ADDR_W-1:0]   in_awaddr,
  input  logic [7:0]          in_awlen,
  input  logic [2:0]          in_awsize,
  input  logic [1:0]          in_awburst,
  input  logic                in_awvalid,
  output logic                in_awready,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  input  logic                in_wlast,
  input  logic                in_wvalid,
  output logic                in_wready,
  output logic [ID_W-1:0]     in_bid,
  output logic [1:0]          in_bresp,
  output logic                in_bvalid,
  input  logic                in_bready,
  input  logic [ID_W-1:0]     in_arid,
  input  logic [ADDR_W-1:0]   in_araddr,
  input  logic [7:0]          in_arlen,
  input  logic [2:0]          in_arsize,
  input  logic [1:0]          in_arburst,
  input  logic                in_arvalid,
  output logic                in_arready,
  output logic [ID_W-1:0]     in_rid,
  output logic [DATA_W-1:0]   in_rdata,
  output logic [1:0]          in_rresp,
  output logic                in_rlast,
  output logic                in_rvalid,
  input  logic                in_rready,
  // downstream master side
  output logic [ID_W-1:0]     out_awid,
  output logic [ADDR_W-1:0]   out_awaddr,
  output logic [7:0]          out_awlen,
  output logic [2:0]          out_awsize,
  output logic [1:0]          out_awburst,
  output logic                out_awvalid,
  input  logic                out_awready,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_wlast,
  output logic                out_wvalid,
  input  logic                out_wready,
  input  logic [ID_W-1:0]     out_bid,
  input  logic [1:0]          out_bresp,
  input  logic                out_bvalid,
  output logic                out_bready,
  output logic [ID_W-1:0]     out_arid,
  output logic [ADDR_W-1:0]   out_araddr,
  output logic [7:0]          out_arlen,
  output logic [2:0]          out_arsize,
  output logic [1:0]          out_arburst,
  output logic                out_arvalid,
  input  logic                out_arready,
  input  logic [ID_W-1:0]     out_rid,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  input  logic                out_rlast,
  input  logic                out_rvalid,
  output logic                out_rready
);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Request payloads and the W channel are never delayed
  assign out_awid    = in_awid;
  assign out_awaddr  = in_awaddr;
  assign out_awlen   = in_awlen;
  assign out_awsize  = in_awsize;
  assign out_awburst = in_awburst;
  assign out_wdata   = in_wdata;
  assign out_wstrb   = in_wstrb;
  assign out_wlast   = in_wlast;
  assign out_wvalid  = in_wvalid;
  assign in_wready   = out_wready;
  assign out_arid    = in_arid;
  assign out_araddr  = in_araddr;
  assign out_arlen   = in_arlen;
  assign out_arsize  = in_arsize;
  assign out_arburst = in_arburst;

  generate
    if (ENABLE == 0) begin : g_bypass
      assign out_awvalid = in_awvalid;
      assign in_awready  = out_awready;
      assign out_arvalid = in_arvalid;
      assign in_arready  = out_arready;
      assign in_bid      = out_bid;
      assign in_bresp    = out_bresp;
      assign in_bvalid   = out_bvalid;
      assign out_bready  = in_bready;
      assign in_rid      = out_rid;
      assign in_rdata    = out_rdata;
      assign in_rresp    = out_rresp;
      assign in_rlast    = out_rlast;
      assign in_rvalid   = out_rvalid;
      assign out_rready  = in_rready;
    end else begin : g_delay
      typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;
      typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_HOLD} w_state_t;
      localparam int PW = $clog2(DEPTH);
      localparam logic [31:0] LAT = 32'(LAT_MUL);
      localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

      r_state_t          r_state;
      logic [31:0]       r_timer, r_acc;
      logic [ID_W-1:0]   f_id   [DEPTH];
      logic [DATA_W-1:0] f_data [DEPTH];
      logic [1:0]        f_resp [DEPTH];
      logic              f_last [DEPTH];
      logic [31:0]       f_rel  [DEPTH];
      logic [PW-1:0]     wr_ptr, rd_ptr;
      logic [PW:0]       count;
      logic              ar_hs, r_push, r_pop, head_ok;

      w_state_t          w_state;
      logic [31:0]       w_timer, w_acc, b_rel;
      logic [ID_W-1:0]   b_id;
      logic [1:0]        b_resp;
      logic              aw_hs, b_ok;

      // Timers count cycles since the address handshake; cycle 0 is the handshake itself,
      // so the registers hold 1 / LAT_MUL on entry to the active state.
      assign ar_hs       = (r_state == R_IDLE) && in_arvalid && out_arready;
      assign out_arvalid = (r_state == R_IDLE) && in_arvalid;
      assign in_arready  = (r_state == R_IDLE) && out_arready;
      assign out_rready  = (r_state == R_ACTIVE) && (count < FULL);
      assign r_push      = out_rvalid && out_rready;
      assign head_ok     = (count != '0) && (f_rel[rd_ptr] <= r_timer);
      assign r_pop       = head_ok && in_rready;
      assign in_rvalid   = head_ok;
      assign in_rid      = head_ok ? f_id[rd_ptr]   : '0;
      assign in_rdata    = head_ok ? f_data[rd_ptr] : '0;
      assign in_rresp    = head_ok ? f_resp[rd_ptr] : '0;
      assign in_rlast    = head_ok ? f_last[rd_ptr] : 1'b0;

      // Read FSM with its cycle timer and latency accumulator
      always_ff @(posedge clock) begin
        if (reset) begin
          r_state <= R_IDLE;
          r_timer <= '0;
          r_acc   <= '0;
        end else begin
          case (r_state)
            R_IDLE: if (ar_hs) begin
              r_state <= R_ACTIVE;
              r_timer <= 32'd1;
              r_acc   <= LAT;
            end
            R_ACTIVE: begin
              r_timer <= sat_add(r_timer, 32'd1);
              r_acc   <= sat_add(r_acc, LAT);
              if (r_pop && f_last[rd_ptr]) r_state <= R_IDLE;
            end
            default: r_state <= R_IDLE;
          endcase
        end
      end

      // Beat storage; each entry carries the cycle at which it may be released
      always_ff @(posedge clock) begin
        if (r_push) begin
          f_id[wr_ptr]   <= out_rid;
          f_data[wr_ptr] <= out_rdata;
          f_resp[wr_ptr] <= out_rresp;
          f_last[wr_ptr] <= out_rlast;
          f_rel[wr_ptr]  <= r_acc;
        end
      end

      // Beat buffer pointers and occupancy
      always_ff @(posedge clock) begin
        if (reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (r_push) wr_ptr <= wr_ptr + PW'(1);
          if (r_pop)  rd_ptr <= rd_ptr + PW'(1);
          case ({r_push, r_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
          endcase
        end
      end

      assign aw_hs       = (w_state == W_IDLE) && in_awvalid && out_awready;
      assign out_awvalid = (w_state == W_IDLE) && in_awvalid;
      assign in_awready  = (w_state == W_IDLE) && out_awready;
      assign out_bready  = (w_state == W_ACTIVE);
      assign b_ok        = (w_state == W_HOLD) && (b_rel <= w_timer);
      assign in_bvalid   = b_ok;
      assign in_bid      = b_ok ? b_id   : '0;
      assign in_bresp    = b_ok ? b_resp : '0;

      // Write FSM: capture the B response, then hold it until its release cycle
      always_ff @(posedge clock) begin
        if (reset) begin
          w_state <= W_IDLE;
          w_timer <= '0;
          w_acc   <= '0;
          b_rel   <= '0;
          b_id    <= '0;
          b_resp  <= '0;
        end else begin
          case (w_state)
            W_IDLE: if (aw_hs) begin
              w_state <= W_ACTIVE;
              w_timer <= 32'd1;
              w_acc   <= LAT;
            end
            W_ACTIVE: begin
              w_timer <= sat_add(w_timer, 32'd1);
              w_acc   <= sat_add(w_acc, LAT);
              if (out_bvalid) begin
                b_id    <= out_bid;
                b_resp  <= out_bresp;
                b_rel   <= w_acc;
                w_state <= W_HOLD;
              end
            end
            W_HOLD: begin
              w_timer <= sat_add(w_timer, 32'd1);
              w_acc   <= sat_add(w_acc, LAT);
              if (b_ok && in_bready) w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_axi4_burst_delayer.sv
// tb/tb_axi4_burst_delayer.sv - directed bench for axi4_burst_delayer
module tb_axi4_burst_delayer;
  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [3:0]  in_awid, out_awid, in_arid, out_arid, in_bid, out_bid, in_rid, out_rid;
  logic [31:0] in_awaddr, out_awaddr, in_araddr, out_araddr;
  logic [7:0]  in_awlen, out_awlen, in_arlen, out_arlen;
  logic [2:0]  in_awsize, out_awsize, in_arsize, out_arsize;
  logic [1:0]  in_awburst, out_awburst, in_arburst, out_arburst;
  logic        in_awvalid, in_awready, out_awvalid, out_awready;
  logic [63:0] in_wdata, out_wdata, in_rdata, out_rdata;
  logic [7:0]  in_wstrb, out_wstrb;
  logic        in_wlast, out_wlast, in_wvalid, out_wvalid, in_wready, out_wready;
  logic [1:0]  in_bresp, out_bresp, in_rresp, out_rresp;
  logic        in_bvalid, in_bready, out_bvalid, out_bready;
  logic        in_arvalid, in_arready, out_arvalid, out_arready;
  logic        in_rlast, out_rlast, in_rvalid, in_rready, out_rvalid, out_rready;

  axi4_burst_delayer #(
    .ID_W(4), .ADDR_W(32), .DATA_W(64), .LAT_MUL(5), .DEPTH(4), .ENABLE(1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_awid(in_awid), .in_awaddr(in_awaddr), .in_awlen(in_awlen), .in_awsize(in_awsize),
    .in_awburst(in_awburst), .in_awvalid(in_awvalid), .in_awready(in_awready),
    .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast), .in_wvalid(in_wvalid),
    .in_wready(in_wready),
    .in_bid(in_bid), .in_bresp(in_bresp), .in_bvalid(in_bvalid), .in_bready(in_bready),
    .in_arid(in_arid), .in_araddr(in_araddr), .in_arlen(in_arlen), .in_arsize(in_arsize),
    .in_arburst(in_arburst), .in_arvalid(in_arvalid), .in_arready(in_arready),
    .in_rid(in_rid), .in_rdata(in_rdata), .in_rresp(in_rresp), .in_rlast(in_rlast),
    .in_rvalid(in_rvalid), .in_rready(in_rready),
    .out_awid(out_awid), .out_awaddr(out_awaddr), .out_awlen(out_awlen), .out_awsize(out_awsize),
    .out_awburst(out_awburst), .out_awvalid(out_awvalid), .out_awready(out_awready),
    .out_wdata(out_wdata), .out_wstrb(out_wstrb), .out_wlast(out_wlast), .out_wvalid(out_wvalid),
    .out_wready(out_wready),
    .out_bid(out_bid), .out_bresp(out_bresp), .out_bvalid(out_bvalid), .out_bready(out_bready),
    .out_arid(out_arid), .out_araddr(out_araddr), .out_arlen(out_arlen), .out_arsize(out_arsize),
    .out_arburst(out_arburst), .out_arvalid(out_arvalid), .out_arready(out_arready),
    .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .out_rvalid(out_rvalid), .out_rready(out_rready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rv_log     [0:127];
  logic [63:0] rdata_log  [0:127];
  logic        rready_log [0:127];
  logic        arready_log[0:127];
  int          up_cyc [0:15];
  logic [63:0] up_data[0:15];
  logic        up_last[0:15];
  int          up_n;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One read burst: AR in cycle 0, downstream beats from cycle 'first', upstream stalls in [slo,shi],
  // optional reset pulse in cycle rst_cyc. Logs upstream handshakes and per-cycle observations.
  task automatic run_read(input int arlen, input int first, input int slo, input int shi,
                          input int rst_cyc, input int ncyc);
    int bi;
    bi = 0;
    up_n = 0;
    for (int i = 0; i < 16; i++) begin
      up_cyc[i] = -1;
      up_data[i] = '0;
      up_last[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      reset      = (c == rst_cyc);
      in_arvalid = (c == 0);
      in_arid    = 4'h5;
      in_araddr  = 32'h0000_1000;
      in_arlen   = 8'(arlen);
      out_rvalid = (c >= first) && (bi <= arlen);
      out_rid    = 4'h5;
      out_rdata  = {48'hA5A5_0000_0000, 16'(bi)};
      out_rresp  = 2'(bi);
      out_rlast  = (bi == arlen);
      in_rready  = !((c >= slo) && (c <= shi));
      @(negedge clock);
      rv_log[c]      = in_rvalid;
      rdata_log[c]   = in_rdata;
      rready_log[c]  = out_rready;
      arready_log[c] = in_arready;
      if (out_rvalid && out_rready) bi++;
      if (in_rvalid && in_rready && up_n < 16) begin
        up_cyc[up_n]  = c;
        up_data[up_n] = in_rdata;
        up_last[up_n] = in_rlast;
        up_n++;
      end
      @(posedge clock);
      #1;
    end
    reset      = 1'b0;
    in_arvalid = 1'b0;
    out_rvalid = 1'b0;
    in_rready  = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_cmp++; if (in_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_in_rvalid: got %b want 0", in_rvalid); end
    n_cmp++; if (in_bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_in_bvalid: got %b want 0", in_bvalid); end
    n_cmp++; if (out_rready !== 1'b0) begin n_bad++; $display("FAIL reset_out_rready: got %b want 0", out_rready); end
    n_cmp++; if (out_bready !== 1'b0) begin n_bad++; $display("FAIL reset_out_bready: got %b want 0", out_bready); end
    n_cmp++; if (in_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_in_rdata: got %h want 0", in_rdata); end
    n_cmp++; if (in_arready !== 1'b1) begin n_bad++; $display("FAIL reset_in_arready: got %b want 1", in_arready); end
    n_cmp++; if (in_awready !== 1'b1) begin n_bad++; $display("FAIL reset_in_awready: got %b want 1", in_awready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_passthrough();
    out_awready = 1'b0;
    out_arready = 1'b0;
    in_awvalid  = 1'b1;
    in_awaddr   = 32'hDEAD_BEE0;
    in_awlen    = 8'd7;
    in_wdata    = 64'h0123_4567_89AB_CDEF;
    in_wstrb    = 8'h5A;
    in_wlast    = 1'b1;
    in_wvalid   = 1'b1;
    out_wready  = 1'b1;
    in_arvalid  = 1'b1;
    in_araddr   = 32'h0000_4000;
    @(negedge clock);
    n_cmp++; if (out_awvalid !== 1'b1) begin n_bad++; $display("FAIL pt_awvalid: got %b want 1", out_awvalid); end
    n_cmp++; if (out_awaddr !== 32'hDEAD_BEE0) begin n_bad++; $display("FAIL pt_awaddr: got %h want deadbee0", out_awaddr); end
    n_cmp++; if (out_awlen !== 8'd7) begin n_bad++; $display("FAIL pt_awlen: got %0d want 7", out_awlen); end
    n_cmp++; if (out_wdata !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL pt_wdata: got %h want 0123456789abcdef", out_wdata); end
    n_cmp++; if (out_wstrb !== 8'h5A) begin n_bad++; $display("FAIL pt_wstrb: got %h want 5a", out_wstrb); end
    n_cmp++; if (in_wready !== 1'b1) begin n_bad++; $display("FAIL pt_wready: got %b want 1", in_wready); end
    n_cmp++; if (out_arvalid !== 1'b1) begin n_bad++; $display("FAIL pt_arvalid: got %b want 1", out_arvalid); end
    n_cmp++; if (out_araddr !== 32'h0000_4000) begin n_bad++; $display("FAIL pt_araddr: got %h want 00004000", out_araddr); end
    n_cmp++; if (in_arready !== 1'b0) begin n_bad++; $display("FAIL pt_arready: got %b want 0", in_arready); end
    @(posedge clock);
    #1;
    in_awvalid  = 1'b0;
    in_wvalid   = 1'b0;
    in_arvalid  = 1'b0;
    out_wready  = 1'b0;
    out_awready = 1'b1;
    out_arready = 1'b1;
  endtask

  task automatic test_single_beat();
    run_read(0, 3, -1, -1, -1, 20);
    n_cmp++; if (arready_log[0] !== 1'b1) begin n_bad++; $display("FAIL single_ar_accept: got %b want 1", arready_log[0]); end
    n_cmp++; if (up_n !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", up_n); end
    n_cmp++; if (rv_log[14] !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", rv_log[14]); end
    n_cmp++; if (up_cyc[0] !== 15) begin n_bad++; $display("FAIL single_cycle: got %0d want 15", up_cyc[0]); end
    n_cmp++; if (up_last[0] !== 1'b1) begin n_bad++; $display("FAIL single_last: got %b want 1", up_last[0]); end
    n_cmp++; if (up_data[0] !== 64'hA5A5_0000_0000_0000) begin n_bad++; $display("FAIL single_data: got %h want a5a5000000000000", up_data[0]); end
    n_cmp++; if (arready_log[15] !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", arready_log[15]); end
    n_cmp++; if (arready_log[16] !== 1'b1) begin n_bad++; $display("FAIL single_idle: got %b want 1", arready_log[16]); end
    n_cmp++; if (rready_log[2] !== 1'b1) begin n_bad++; $display("FAIL single_rready: got %b want 1", rready_log[2]); end
    n_cmp++; if (rready_log[16] !== 1'b0) begin n_bad++; $display("FAIL single_rready_idle: got %b want 0", rready_log[16]); end
  endtask

  task automatic test_burst();
    int exp_c[4] = '{15, 20, 25, 30};
    run_read(3, 3, -1, -1, -1, 40);
    n_cmp++; if (up_n !== 4) begin n_bad++; $display("FAIL burst_count: got %0d want 4", up_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (up_cyc[i] !== exp_c[i]) begin n_bad++; $display("FAIL burst_cycle[%0d]: got %0d want %0d", i, up_cyc[i], exp_c[i]); end
      n_cmp++; if (up_data[i] !== {48'hA5A5_0000_0000, 16'(i)}) begin n_bad++; $display("FAIL burst_data[%0d]: got %h", i, up_data[i]); end
      n_cmp++; if (up_last[i] !== (i == 3)) begin n_bad++; $display("FAIL burst_last[%0d]: got %b want %b", i, up_last[i], i == 3); end
    end
  endtask

  task automatic test_stall();
    run_read(3, 3, 20, 22, -1, 40);
    n_cmp++; if (up_cyc[1] !== 23) begin n_bad++; $display("FAIL stall_beat1: got %0d want 23", up_cyc[1]); end
    n_cmp++; if (up_cyc[2] !== 25) begin n_bad++; $display("FAIL stall_beat2: got %0d want 25", up_cyc[2]); end
    n_cmp++; if (up_cyc[3] !== 30) begin n_bad++; $display("FAIL stall_beat3: got %0d want 30", up_cyc[3]); end
    for (int c = 20; c <= 23; c++) begin
      n_cmp++; if (rv_log[c] !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, rv_log[c]); end
      n_cmp++; if (rdata_log[c] !== 64'hA5A5_0000_0000_0001) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want a5a5000000000001", c, rdata_log[c]); end
    end
  endtask

  task automatic test_backpressure();
    int exp_c[8] = '{5, 10, 15, 20, 30, 55, 80, 105};
    run_read(7, 1, -1, -1, -1, 115);
    n_cmp++; if (rready_log[4] !== 1'b1) begin n_bad++; $display("FAIL bp_rready4: got %b want 1", rready_log[4]); end
    n_cmp++; if (rready_log[5] !== 1'b0) begin n_bad++; $display("FAIL bp_rready5: got %b want 0", rready_log[5]); end
    n_cmp++; if (rready_log[6] !== 1'b1) begin n_bad++; $display("FAIL bp_rready6: got %b want 1", rready_log[6]); end
    n_cmp++; if (rready_log[7] !== 1'b0) begin n_bad++; $display("FAIL bp_rready7: got %b want 0", rready_log[7]); end
    n_cmp++; if (up_n !== 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", up_n); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (up_cyc[i] !== exp_c[i]) begin n_bad++; $display("FAIL bp_cycle[%0d]: got %0d want %0d", i, up_cyc[i], exp_c[i]); end
      n_cmp++; if (up_data[i] !== {48'hA5A5_0000_0000, 16'(i)}) begin n_bad++; $display("FAIL bp_data[%0d]: got %h", i, up_data[i]); end
      n_cmp++; if (up_last[i] !== (i == 7)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b want %b", i, up_last[i], i == 7); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int late;
    late = 0;
    run_read(3, 3, -1, -1, 10, 45);
    for (int c = 11; c < 45; c++) late += int'(rv_log[c]);
    n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL rst_no_rvalid: got %0d cycles want 0", late); end
    n_cmp++; if (up_n !== 0) begin n_bad++; $display("FAIL rst_no_beats: got %0d want 0", up_n); end
    n_cmp++; if (rready_log[11] !== 1'b0) begin n_bad++; $display("FAIL rst_rready: got %b want 0", rready_log[11]); end
    n_cmp++; if (arready_log[11] !== 1'b1) begin n_bad++; $display("FAIL rst_arready: got %b want 1", arready_log[11]); end
    run_read(0, 3, -1, -1, -1, 20);
    n_cmp++; if (arready_log[0] !== 1'b1) begin n_bad++; $display("FAIL rst_next_ar: got %b want 1", arready_log[0]); end
    n_cmp++; if (up_cyc[0] !== 15) begin n_bad++; $display("FAIL rst_next_cycle: got %0d want 15", up_cyc[0]); end
  endtask

  task automatic test_write();
    logic       aw_log[0:39];
    logic       bb_log[0:39];
    logic       bv_log[0:39];
    logic [3:0] bid_log[0:39];
    logic [1:0] bresp_log[0:39];
    bit         bdone;
    int         first_bv;
    bdone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_awvalid = (c == 0);
      in_awid    = 4'h3;
      in_awaddr  = 32'h0000_2000;
      out_bvalid = (c >= 6) && !bdone;
      out_bid    = 4'h3;
      out_bresp  = 2'd2;
      in_bready  = 1'b1;
      @(negedge clock);
      aw_log[c]    = in_awready;
      bb_log[c]    = out_bready;
      bv_log[c]    = in_bvalid;
      bid_log[c]   = in_bid;
      bresp_log[c] = in_bresp;
      if (out_bvalid && out_bready) bdone = 1'b1;
      @(posedge clock);
      #1;
    end
    in_awvalid = 1'b0;
    out_bvalid = 1'b0;
    first_bv = -1;
    for (int c = 0; c < 40; c++) if (bv_log[c] && first_bv < 0) first_bv = c;
    n_cmp++; if (aw_log[0] !== 1'b1) begin n_bad++; $display("FAIL wr_aw_accept: got %b want 1", aw_log[0]); end
    n_cmp++; if (bb_log[6] !== 1'b1) begin n_bad++; $display("FAIL wr_bready6: got %b want 1", bb_log[6]); end
    n_cmp++; if (bb_log[7] !== 1'b0) begin n_bad++; $display("FAIL wr_bready7: got %b want 0", bb_log[7]); end
    n_cmp++; if (first_bv !== 30) begin n_bad++; $display("FAIL wr_bvalid_cycle: got %0d want 30", first_bv); end
    n_cmp++; if (bid_log[30] !== 4'h3) begin n_bad++; $display("FAIL wr_bid: got %h want 3", bid_log[30]); end
    n_cmp++; if (bresp_log[30] !== 2'd2) begin n_bad++; $display("FAIL wr_bresp: got %0d want 2", bresp_log[30]); end
    n_cmp++; if (bid_log[29] !== 4'h0) begin n_bad++; $display("FAIL wr_bid_idle: got %h want 0", bid_log[29]); end
    n_cmp++; if (bv_log[31] !== 1'b0) begin n_bad++; $display("FAIL wr_bvalid_after: got %b want 0", bv_log[31]); end
    n_cmp++; if (aw_log[30] !== 1'b0) begin n_bad++; $display("FAIL wr_awready30: got %b want 0", aw_log[30]); end
    n_cmp++; if (aw_log[31] !== 1'b1) begin n_bad++; $display("FAIL wr_awready31: got %b want 1", aw_log[31]); end
  endtask

  initial begin
    in_awid = '0; in_awaddr = '0; in_awlen = '0; in_awsize = 3'd3; in_awburst = 2'd1; in_awvalid = 1'b0;
    in_wdata = '0; in_wstrb = '0; in_wlast = 1'b0; in_wvalid = 1'b0; in_bready = 1'b1;
    in_arid = '0; in_araddr = '0; in_arlen = '0; in_arsize = 3'd3; in_arburst = 2'd1; in_arvalid = 1'b0;
    in_rready = 1'b1;
    out_awready = 1'b1; out_wready = 1'b0; out_bid = '0; out_bresp = '0; out_bvalid = 1'b0;
    out_arready = 1'b1; out_rid = '0; out_rdata = '0; out_rresp = '0; out_rlast = 1'b0; out_rvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    idle(1);
    test_passthrough();
    idle(2);
    test_single_beat();
    idle(2);
    test_burst();
    idle(2);
    test_stall();
    idle(2);
    test_backpressure();
    idle(2);
    test_reset_mid_burst();
    idle(2);
    test_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
